// File: rtl/cnn_frame_sequencer_if.sv
// Purpose : groups the request, pixel-memory, core and result signals of cnn_frame_sequencer.
// Latency : n/a (signal bundle only).
// Backpressure: req_valid/req_ready handshake on the request side; no backpressure on results.
//
// Modports:
//   master - the sequencer: consumes requests, reads memory, drives the core, emits results.
//   slave  - the environment: host request path, pixel memory and CNN core.
interface cnn_frame_sequencer_if #(
    parameter int ADDR_W = 20
);
    // host request path
    logic              req_valid;
    logic              req_ready;
    logic [9:0]        req_frame_idx;
    logic [3:0]        req_label;
    // shared pixel memory
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    // CNN core
    logic              core_rst_n;
    logic [7:0]        core_data;
    logic              core_data_valid;
    logic              core_finish;
    logic [3:0]        core_decision;
    // per-frame result
    logic              res_valid;
    logic [3:0]        res_decision;
    logic              res_hit;
    logic              res_timeout;
    logic [9:0]        res_frame_idx;

    modport master (
        input  req_valid, req_frame_idx, req_label, mem_rdata, core_finish, core_decision,
        output req_ready, mem_rd_en, mem_addr, core_rst_n, core_data, core_data_valid,
               res_valid, res_decision, res_hit, res_timeout, res_frame_idx
    );

    modport slave (
        output req_valid, req_frame_idx, req_label, mem_rdata, core_finish, core_decision,
        input  req_ready, mem_rd_en, mem_addr, core_rst_n, core_data, core_data_valid,
               res_valid, res_decision, res_hit, res_timeout, res_frame_idx
    );
endinterface

// File: rtl/cnn_frame_sequencer.sv
// Purpose : sequences the CNN core one frame at a time: core reset, pixel stream, wait, score.
// Latency : RST_CYCLES + PIXELS + 2 cycles to the last pixel, then up to TIMEOUT_CYCLES for finish.
// Backpressure: req_ready only in IDLE; results are one-cycle pulses with no backpressure.
//
// Ports: clk/rst_n (async active-low); bus (cnn_frame_sequencer_if.master) carries request,
// memory, core and result signals; frame_count/hit_count saturating totals; busy = not IDLE;
// stat_class selects the per-class counters returned on stat_hit/stat_miss.
// Optional feature macro: CNN_SEQ_CLASS_STATS_EN builds the per-class hit/miss counters;
// without it stat_hit/stat_miss are tied to 0.
module cnn_frame_sequencer #(
    parameter int PIXELS         = 784,
    parameter int RST_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int ADDR_W         = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cnn_frame_sequencer_if.master bus,
    output logic [9:0]            frame_count,
    output logic [9:0]            hit_count,
    output logic                  busy,
    input  logic [3:0]            stat_class,
    output logic [9:0]            stat_hit,
    output logic [9:0]            stat_miss
);
    localparam int MAX_CNT = (TIMEOUT_CYCLES > PIXELS) ? TIMEOUT_CYCLES : PIXELS;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [9:0] SAT = 10'h3FF;

    typedef enum logic [2:0] {S_IDLE, S_CRST, S_STREAM, S_DRAIN, S_WAIT, S_REPORT} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;          // shared by CRST, STREAM, DRAIN and WAIT
    logic [9:0]        idx_q;
    logic [3:0]        label_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_rd_en_q;
    logic              req_ready_q;
    logic              core_rst_n_q;
    logic              res_valid_q;
    logic [3:0]        res_decision_q;
    logic              res_hit_q;
    logic              res_timeout_q;
    logic [9:0]        res_frame_idx_q;
    logic [9:0]        frame_count_q;
    logic [9:0]        hit_count_q;
    logic              rd_d1_q;        // read issued last cycle -> mem_rdata valid now
    logic              core_data_valid_q;
    logic [7:0]        core_data_q;

    logic [ADDR_W-1:0] base_d;
    logic              hit_d;
    logic [9:0]        frame_count_d;
    logic [9:0]        hit_count_d;

    // Product is taken modulo 2^ADDR_W on purpose.
    assign base_d        = ADDR_W'(bus.req_frame_idx) * ADDR_W'(PIXELS);
    // Labels above 9 are not real classes and can never score a hit.
    assign hit_d         = (label_q <= 4'd9) && (bus.core_decision == label_q);
    assign frame_count_d = (frame_count_q != SAT) ? frame_count_q + 10'd1 : frame_count_q;
    assign hit_count_d   = (res_hit_q && hit_count_q != SAT) ? hit_count_q + 10'd1 : hit_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            idx_q           <= '0;
            label_q         <= '0;
            base_q          <= '0;
            mem_addr_q      <= '0;
            mem_rd_en_q     <= 1'b0;
            req_ready_q     <= 1'b0;
            core_rst_n_q    <= 1'b0;
            res_valid_q     <= 1'b0;
            res_decision_q  <= '0;
            res_hit_q       <= 1'b0;
            res_timeout_q   <= 1'b0;
            res_frame_idx_q <= '0;
            frame_count_q   <= '0;
            hit_count_q     <= '0;
        end else begin
            res_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        idx_q        <= bus.req_frame_idx;
                        label_q      <= bus.req_label;
                        base_q       <= base_d;
                        req_ready_q  <= 1'b0;
                        core_rst_n_q <= 1'b0;
                        cnt_q        <= '0;
                        state_q      <= S_CRST;
                    end else begin
                        req_ready_q  <= 1'b1;
                        core_rst_n_q <= 1'b1;
                    end
                end
                S_CRST: begin
                    if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                        core_rst_n_q <= 1'b1;
                        mem_rd_en_q  <= 1'b1;
                        mem_addr_q   <= base_q;
                        cnt_q        <= '0;
                        state_q      <= S_STREAM;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_STREAM: begin
                    if (cnt_q == CNT_W'(PIXELS - 1)) begin
                        mem_rd_en_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= S_DRAIN;
                    end else begin
                        mem_addr_q <= mem_addr_q + ADDR_W'(1);
                        cnt_q      <= cnt_q + CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    // Covers the memory read plus the core_data register.
                    if (cnt_q == CNT_W'(1)) begin
                        cnt_q   <= '0;
                        state_q <= S_WAIT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    // finish is tested first so it wins over a same-cycle timeout
                    if (bus.core_finish) begin
                        res_valid_q     <= 1'b1;
                        res_decision_q  <= bus.core_decision;
                        res_hit_q       <= hit_d;
                        res_timeout_q   <= 1'b0;
                        res_frame_idx_q <= idx_q;
                        state_q         <= S_REPORT;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        res_valid_q     <= 1'b1;
                        res_decision_q  <= 4'hF;
                        res_hit_q       <= 1'b0;
                        res_timeout_q   <= 1'b1;
                        res_frame_idx_q <= idx_q;
                        state_q         <= S_REPORT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_REPORT: begin
                    frame_count_q <= frame_count_d;
                    hit_count_q   <= hit_count_d;
                    req_ready_q   <= 1'b1;
                    state_q       <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Two-stage pixel path: memory read latency, then the core_data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_d1_q           <= 1'b0;
            core_data_valid_q <= 1'b0;
            core_data_q       <= '0;
        end else begin
            rd_d1_q           <= mem_rd_en_q;
            core_data_valid_q <= rd_d1_q;
            core_data_q       <= rd_d1_q ? bus.mem_rdata : 8'h00;
        end
    end

`ifdef CNN_SEQ_CLASS_STATS_EN
    logic [9:0] cls_hit_q  [10];
    logic [9:0] cls_miss_q [10];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 10; i++) begin
                cls_hit_q[i]  <= '0;
                cls_miss_q[i] <= '0;
            end
        end else if (state_q == S_REPORT && label_q <= 4'd9) begin
            // a timeout carries res_hit_q=0 and therefore lands in the miss bin
            if (res_hit_q) begin
                if (cls_hit_q[label_q] != SAT) cls_hit_q[label_q] <= cls_hit_q[label_q] + 10'd1;
            end else begin
                if (cls_miss_q[label_q] != SAT) cls_miss_q[label_q] <= cls_miss_q[label_q] + 10'd1;
            end
        end
    end

    assign stat_hit  = (stat_class <= 4'd9) ? cls_hit_q[stat_class]  : 10'd0;
    assign stat_miss = (stat_class <= 4'd9) ? cls_miss_q[stat_class] : 10'd0;
`else
    logic unused_stat_class;
    assign unused_stat_class = ^stat_class;
    assign stat_hit  = 10'd0;
    assign stat_miss = 10'd0;
`endif

    assign bus.req_ready       = req_ready_q;
    assign bus.mem_rd_en       = mem_rd_en_q;
    assign bus.mem_addr        = mem_addr_q;
    assign bus.core_rst_n      = core_rst_n_q;
    assign bus.core_data       = core_data_q;
    assign bus.core_data_valid = core_data_valid_q;
    assign bus.res_valid       = res_valid_q;
    assign bus.res_decision    = res_decision_q;
    assign bus.res_hit         = res_hit_q;
    assign bus.res_timeout     = res_timeout_q;
    assign bus.res_frame_idx   = res_frame_idx_q;
    assign frame_count         = frame_count_q;
    assign hit_count           = hit_count_q;
    assign busy                = (state_q != S_IDLE);
endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Purpose : scoreboard bench for cnn_frame_sequencer (784-pixel instance plus a 4-pixel
//           instance used to reach counter saturation in few cycles).
// Latency : expected results queued at request time, popped when res_valid appears.
// Backpressure: req_valid held until req_ready; results are never stalled.
module tb_cnn_frame_sequencer;
`ifdef CNN_SEQ_CLASS_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    typedef struct packed {
        logic [9:0] idx;
        logic [3:0] dec;
        logic       hit;
        logic       to;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       srst_n;
    logic [3:0] stat_class;
    logic [3:0] sstat_class;
    logic [9:0] frame_count, hit_count, stat_hit, stat_miss;
    logic [9:0] sframe_count, shit_count, sstat_hit, sstat_miss;
    logic       busy, sbusy;

    int errs = 0;
    int chks = 0;
    int cyc = 0;
    int res_seen = 0;
    int sat_n = 0;
    bit sat_done = 0;

    exp_t        rq[$];     // expected results
    logic [19:0] bq[$];     // expected base addresses
    logic [7:0]  pq[$];     // expected pixels in flight
    logic [3:0]  cdq[$];    // core model: decision per frame
    bit          cnq[$];    // core model: never finish

    logic [19:0] exp_addr, first_addr, last_addr;
    int rd_cnt, vcnt, crst_cnt, first_v, last_v;

    cnn_frame_sequencer_if #(.ADDR_W(20)) bif ();
    cnn_frame_sequencer_if #(.ADDR_W(20)) sif ();

    cnn_frame_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bif),
        .frame_count(frame_count), .hit_count(hit_count), .busy(busy),
        .stat_class(stat_class), .stat_hit(stat_hit), .stat_miss(stat_miss)
    );

    cnn_frame_sequencer #(.PIXELS(4), .TIMEOUT_CYCLES(16)) u_sat (
        .clk(clk), .rst_n(srst_n), .bus(sif),
        .frame_count(sframe_count), .hit_count(shit_count), .busy(sbusy),
        .stat_class(sstat_class), .stat_hit(sstat_hit), .stat_miss(sstat_miss)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [7:0] pix(input logic [19:0] a);
        return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Synchronous pixel memory: data one cycle after the read strobe.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bif.mem_rdata <= 8'h00;
        else if (bif.mem_rd_en) bif.mem_rdata <= pix(bif.mem_addr);
    end

    // Core model: spurious finish at the 100th pixel, real finish 3 cycles into WAIT.
    int cm_v, cm_dly;
    bit cm_prev;
    logic [3:0] cm_dec;
    always @(negedge clk) begin
        if (!rst_n) begin
            bif.core_finish = 1'b0; bif.core_decision = 4'h0;
            cm_v = 0; cm_dly = 0; cm_prev = 0; cm_dec = 4'h0;
        end else begin
            bif.core_finish = 1'b0; bif.core_decision = 4'h0;
            if (bif.core_data_valid) begin
                cm_v++;
                if (cm_v == 100) begin bif.core_finish = 1'b1; bif.core_decision = 4'hA; end
            end
            if (cm_prev && !bif.core_data_valid) begin
                cm_v = 0;
                if (cdq.size() > 0) begin
                    cm_dec = cdq.pop_front();
                    cm_dly = cnq.pop_front() ? 0 : 3;
                end
            end else if (cm_dly > 0) begin
                cm_dly--;
                if (cm_dly == 0) begin bif.core_finish = 1'b1; bif.core_decision = cm_dec; end
            end
            cm_prev = bif.core_data_valid;
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            pq.delete();
            rd_cnt = 0; vcnt = 0; crst_cnt = 0; first_v = 0; last_v = 0;
        end else begin
            if (busy) chk("req_ready_busy", bif.req_ready, 0);
            if (!bif.core_rst_n && busy) crst_cnt++;
            if (bif.mem_rd_en) begin
                if (rd_cnt == 0) begin
                    exp_addr = (bq.size() > 0) ? bq.pop_front() : 20'hFFFFF;
                    first_addr = bif.mem_addr;
                end
                chk("mem_addr", bif.mem_addr, exp_addr);
                exp_addr = exp_addr + 20'd1;
                last_addr = bif.mem_addr;
                rd_cnt++;
                pq.push_back(pix(bif.mem_addr));
            end
            if (bif.core_data_valid) begin
                if (vcnt == 0) first_v = cyc;
                last_v = cyc;
                vcnt++;
                chk("core_data", bif.core_data, (pq.size() > 0) ? pq.pop_front() : 8'hxx);
            end
            if (bif.res_valid) begin
                res_seen++;
                if (rq.size() == 0) begin
                    chk("res_unexpected", bif.res_valid, 0);
                end else begin
                    exp_t e;
                    e = rq.pop_front();
                    chk("res_decision", bif.res_decision, e.dec);
                    chk("res_hit", bif.res_hit, e.hit);
                    chk("res_timeout", bif.res_timeout, e.to);
                    chk("res_frame_idx", bif.res_frame_idx, e.idx);
                    chk("read_count", rd_cnt, 784);
                    chk("valid_count", vcnt, 784);
                    chk("valid_run", last_v - first_v + 1, 784);
                    chk("core_rst_cycles", crst_cnt, 2);
                    if (e.to) chk("timeout_latency", cyc - last_v, 17);
                end
                rd_cnt = 0; vcnt = 0; crst_cnt = 0;
            end
        end
    end

    task automatic send(input logic [9:0] idx, input logic [3:0] lab, input logic [3:0] dec,
                        input bit never, input bit keep, input bit hit);
        int n = 0;
        @(negedge clk);
        bif.req_valid = 1'b1; bif.req_frame_idx = idx; bif.req_label = lab;
        while (!bif.req_ready && n < 5000) begin @(negedge clk); n++; end
        if (!bif.req_ready) begin
            chk("req_accept_bound", bif.req_ready, 1);
        end else begin
            rq.push_back('{idx: idx, dec: never ? 4'hF : dec, hit: hit, to: never});
            bq.push_back(20'(idx) * 20'd784);
            cdq.push_back(dec);
            cnq.push_back(never);
        end
        @(posedge clk); #1;
        if (!keep) bif.req_valid = 1'b0;
    endtask

    task automatic wait_res(input int target);
        int n = 0;
        while (res_seen < target && n < 5000) begin @(negedge clk); n++; end
        chk("res_arrival_bound", res_seen >= target, 1);
        repeat (2) @(negedge clk);
    endtask

    // Saturation instance: request and finish held high; stop after 1030 results.
    initial begin
        int n = 0;
        srst_n = 1'b0; sstat_class = 4'd4;
        sif.req_valid = 1'b1; sif.req_frame_idx = 10'd0; sif.req_label = 4'd4;
        sif.core_finish = 1'b1; sif.core_decision = 4'd4; sif.mem_rdata = 8'h00;
        repeat (3) @(negedge clk);
        srst_n = 1'b1;
        while (sat_n < 1030 && n < 30000) begin
            @(negedge clk); n++;
            if (sif.res_valid) sat_n++;
        end
        sif.req_valid = 1'b0;
        sat_done = 1;
    end

    initial begin
        int n = 0;
        rst_n = 1'b0; stat_class = 4'd0;
        bif.req_valid = 1'b0; bif.req_frame_idx = '0; bif.req_label = '0;
        repeat (3) @(negedge clk);
        chk("rst_core_rst_n", bif.core_rst_n, 0);
        chk("rst_req_ready", bif.req_ready, 0);
        chk("rst_mem_rd_en", bif.mem_rd_en, 0);
        chk("rst_core_valid", bif.core_data_valid, 0);
        chk("rst_res_valid", bif.res_valid, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", bif.req_ready, 1);
        chk("post_rst_core_rst_n", bif.core_rst_n, 1);

        // idx 0, label 7, core says 7: hit
        send(10'd0, 4'd7, 4'd7, 0, 0, 1);
        wait_res(1);
        chk("f1_frame_count", frame_count, 1);
        chk("f1_hit_count", hit_count, 1);
        stat_class = 4'd7; #1;
        chk("f1_stat_hit7", stat_hit, STATS);
        chk("f1_stat_miss7", stat_miss, 0);

        // idx 999, label 3, core says 5: miss, top-of-memory addresses
        send(10'd999, 4'd3, 4'd5, 0, 0, 0);
        wait_res(2);
        chk("f2_first_addr", first_addr, 783216);
        chk("f2_last_addr", last_addr, 783999);
        chk("f2_frame_count", frame_count, 2);
        chk("f2_hit_count", hit_count, 1);
        chk("f2_res_idx_held", bif.res_frame_idx, 999);
        chk("f2_res_dec_held", bif.res_decision, 5);

        // core never finishes: timeout
        send(10'd5, 4'd2, 4'd0, 1, 0, 0);
        wait_res(3);
        chk("f3_frame_count", frame_count, 3);
        chk("f3_hit_count", hit_count, 1);
        stat_class = 4'd2; #1;
        chk("f3_stat_miss2", stat_miss, STATS);

        // req_valid held across a frame; label 12 cannot hit even when decision matches
        send(10'd1, 4'd9, 4'd9, 0, 1, 1);
        send(10'd2, 4'd12, 4'd12, 0, 0, 0);
        wait_res(5);
        chk("f5_frame_count", frame_count, 5);
        chk("f5_hit_count", hit_count, 2);

        // asynchronous reset in the middle of STREAM
        send(10'd3, 4'd1, 4'd1, 0, 0, 1);
        repeat (300) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_core_rst_n", bif.core_rst_n, 0);
        chk("mid_mem_rd_en", bif.mem_rd_en, 0);
        chk("mid_core_valid", bif.core_data_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_frame_count", frame_count, 0);
        chk("mid_hit_count", hit_count, 0);
        rq.delete(); bq.delete(); cdq.delete(); cnq.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("mid_no_result", res_seen, 5);

        // clean frame after the abort
        send(10'd4, 4'd0, 4'd0, 0, 0, 1);
        wait_res(6);
        chk("f7_frame_count", frame_count, 1);
        chk("f7_hit_count", hit_count, 1);
        stat_class = 4'd0; #1;
        chk("f7_stat_hit0", stat_hit, STATS);

        // saturation on the small instance
        while (!sat_done && n < 40000) begin @(negedge clk); n++; end
        chk("sat_bound", sat_n, 1030);
        repeat (3) @(negedge clk);
        chk("sat_frame_count", sframe_count, 1023);
        chk("sat_hit_count", shit_count, 1023);
        chk("sat_stat_hit4", sstat_hit, STATS ? 1023 : 0);
        chk("sat_stat_miss4", sstat_miss, 0);
        sstat_class = 4'd11; #1;
        chk("sat_stat_hit11", sstat_hit, 0);

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end
endmodule
